// File: rtl/apple_bus_sequencer_pkg.sv
// apple_bus_sequencer_pkg: shared S-state encoding and bus-cycle length constants
package apple_bus_sequencer_pkg;
   typedef logic [2:0] bus_state_t;
   localparam bus_state_t S_IDLE      = 3'd0;
   localparam bus_state_t S_FIRST     = 3'd1;
   localparam bus_state_t S_SAMPLE_LO = 3'd4;
   localparam bus_state_t S_SAMPLE_HI = 3'd5;
   localparam bus_state_t S_SAT       = 3'd7;
   localparam logic [4:0] NORMAL_INTERVAL  = 5'd7;
   localparam logic [4:0] STRETCH_INTERVAL = 5'd8;
   function automatic logic in_sample_win(input bus_state_t s);
      return s == S_SAMPLE_LO || s == S_SAMPLE_HI;
   endfunction
endpackage

// File: rtl/apple_bus_lock_mon.sv
// apple_bus_lock_mon: PHI1 interval counter, lock qualification and bus-clock timeout
import apple_bus_sequencer_pkg::*;
module apple_bus_lock_mon #(
   parameter int LOCK_CYCLES  = 2,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic rise,
   input  logic phi0seen,
   output logic locked,
   output logic timeout,
   output logic stretched
);
   localparam int GW = $clog2(LOCK_CYCLES + 1);
   localparam logic [GW-1:0] GMAX = GW'(LOCK_CYCLES);
   localparam logic [4:0] TMAX = 5'(LOCK_TIMEOUT);
   logic [4:0] t;
   logic [GW-1:0] gc, gc_nx;
   logic good;
   assign good = phi0seen & (t == NORMAL_INTERVAL | t == STRETCH_INTERVAL);
   assign gc_nx = (gc == GMAX) ? GMAX : gc + 1'b1;
   assign timeout = ~rise & (t == TMAX);
   assign stretched = rise & (t == STRETCH_INTERVAL);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         t      <= '0;
         gc     <= '0;
         locked <= 1'b0;
      end else if (rise) begin
         t      <= 5'd1;
         gc     <= good ? gc_nx : '0;
         locked <= good & (gc_nx == GMAX);
      end else begin
         t <= (t == 5'd31) ? t : t + 1'b1;
         if (timeout) begin
            gc     <= '0;
            locked <= 1'b0;
         end
      end
endmodule

// File: rtl/apple_bus_sequencer.sv
// apple_bus_sequencer: locks to PHI1 on C7M and emits S state, drive/sample windows and refresh slot
import apple_bus_sequencer_pkg::*;
module apple_bus_sequencer #(
   parameter int REF_PERIOD   = 13,
   parameter int LOCK_CYCLES  = 2,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic       C7M,
   input  logic       RES,
   input  logic       PHI1,
   output logic [2:0] S,
   output logic       PHI0seen,
   output logic       Locked,
   output logic       DrvEn,
   output logic       SampleWin,
   output logic       RefSlot,
   output logic       Stretch
);
   localparam int RW = $clog2(REF_PERIOD);
   localparam logic [RW-1:0] REF_LAST = RW'(REF_PERIOD - 1);
   logic phi1reg, rise, sync, timeout, stretched;
   logic [RW-1:0] refcnt;
   assign rise = PHI1 & ~phi1reg;
   assign sync = rise & PHI0seen;
   assign SampleWin = in_sample_win(S);
   apple_bus_lock_mon #(
      .LOCK_CYCLES (LOCK_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) u_lock (
      .clk      (C7M),
      .rst      (RES),
      .rise     (rise),
      .phi0seen (PHI0seen),
      .locked   (Locked),
      .timeout  (timeout),
      .stretched(stretched)
   );
   always_ff @(posedge C7M or posedge RES)
      if (RES) begin
         phi1reg  <= 1'b0;
         S        <= S_IDLE;
         PHI0seen <= 1'b0;
         DrvEn    <= 1'b0;
         RefSlot  <= 1'b0;
         Stretch  <= 1'b0;
         refcnt   <= '0;
      end else begin
         phi1reg  <= PHI1;
         PHI0seen <= ~timeout & (PHI0seen | ~PHI1);
         S        <= sync ? S_FIRST : timeout ? S_IDLE : (S == S_IDLE || S == S_SAT) ? S : S + 3'd1;
         DrvEn    <= S[2];
         Stretch  <= stretched & Locked;
         RefSlot  <= sync ? ((refcnt == '0) & Locked) : (RefSlot & (S == S_FIRST));
         if (S == 3'd3)
            refcnt <= (refcnt == REF_LAST) ? '0 : refcnt + 1'b1;
      end
endmodule

// File: tb/tb_apple_bus_sequencer.sv
// tb_apple_bus_sequencer: randomized PHI1 stimulus checked against a tick-count reference model
module tb_apple_bus_sequencer;
   localparam int REF_PERIOD   = 13;
   localparam int LOCK_CYCLES  = 2;
   localparam int LOCK_TIMEOUT = 16;
   logic C7M = 1'b0;
   logic RES = 1'b1;
   logic PHI1 = 1'b0;
   logic [2:0] S;
   logic PHI0seen, Locked, DrvEn, SampleWin, RefSlot, Stretch;
   int checks = 0;
   int errors = 0;
   int m_since, m_pos, m_streak, m_s3;
   bit m_last, m_seen, m_lock, m_refcyc, m_str, m_drv;
   always #5 C7M = ~C7M;
   apple_bus_sequencer #(
      .REF_PERIOD  (REF_PERIOD),
      .LOCK_CYCLES (LOCK_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .C7M      (C7M),
      .RES      (RES),
      .PHI1     (PHI1),
      .S        (S),
      .PHI0seen (PHI0seen),
      .Locked   (Locked),
      .DrvEn    (DrvEn),
      .SampleWin(SampleWin),
      .RefSlot  (RefSlot),
      .Stretch  (Stretch)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask
   function automatic int m_state();
      return m_pos > 7 ? 7 : m_pos;
   endfunction
   task automatic model_reset();
      m_since = 0; m_pos = 0; m_streak = 0; m_s3 = 0;
      m_last = 0; m_seen = 0; m_lock = 0; m_refcyc = 0; m_str = 0; m_drv = 0;
   endtask
   task automatic model_tick(input bit p);
      bit rise, to, good, old_lock, due;
      int s_old;
      s_old    = m_state();
      rise     = p && !m_last;
      to       = !rise && m_since == LOCK_TIMEOUT;
      good     = m_seen && (m_since == 7 || m_since == 8);
      old_lock = m_lock;
      due      = (m_s3 % REF_PERIOD) == 0;
      m_drv    = s_old >= 4;
      m_str    = rise && m_since == 8 && old_lock;
      if (s_old == 3) m_s3++;
      if (rise) begin
         m_streak = good ? m_streak + 1 : 0;
         m_lock   = m_streak >= LOCK_CYCLES;
      end else if (to) begin
         m_streak = 0;
         m_lock   = 0;
      end
      if (rise && m_seen) begin
         m_pos    = 1;
         m_refcyc = old_lock && due;
      end else if (to) m_pos = 0;
      else if (m_pos > 0) m_pos++;
      m_seen  = !to && (m_seen || !p);
      m_since = rise ? 1 : m_since + 1;
      m_last  = p;
   endtask
   task automatic step(input bit p);
      int s;
      PHI1 = p;
      @(posedge C7M);
      #1;
      if (RES) model_reset();
      else model_tick(p);
      s = m_state();
      check("S", 32'(S), 32'(s));
      check("PHI0seen", 32'(PHI0seen), 32'(m_seen));
      check("Locked", 32'(Locked), 32'(m_lock));
      check("DrvEn", 32'(DrvEn), 32'(m_drv));
      check("SampleWin", 32'(SampleWin), 32'(s == 4 || s == 5));
      check("RefSlot", 32'(RefSlot), 32'(m_refcyc && (s == 1 || s == 2)));
      check("Stretch", 32'(Stretch), 32'(m_str));
   endtask
   task automatic cycle(input int len, input int hi);
      for (int i = 0; i < len; i++) step(i < hi);
   endtask
   initial begin
      int n;
      model_reset();
      for (int i = 0; i < 6; i++) step(i[0]);
      #1 RES = 1'b0;
      n = $urandom_range(12, 9);
      for (int i = 0; i < n; i++) step(1'b0);
      for (int c = 0; c < 45; c++)
         cycle(($urandom_range(5, 0) == 0 && c > 5) ? 8 : 7, $urandom_range(4, 2));
      for (int i = 0; i < 20; i++) step(1'b1);
      for (int i = 0; i < 4; i++) step(1'b0);
      for (int c = 0; c < 6; c++) cycle(7, 3);
      for (int c = 0; c < 30; c++) cycle($urandom_range(10, 5), $urandom_range(3, 1));
      for (int c = 0; c < 10; c++) cycle(7, $urandom_range(4, 2));
      for (int i = 0; i < 5; i++) step(i < 3);
      check("pre_reset_S", 32'(S), 32'd5);
      #2 RES = 1'b1;
      #1;
      check("async_S", 32'(S), 32'd0);
      check("async_DrvEn", 32'(DrvEn), 32'd0);
      check("async_Locked", 32'(Locked), 32'd0);
      check("async_RefSlot", 32'(RefSlot), 32'd0);
      model_reset();
      for (int i = 0; i < 3; i++) step(i[0]);
      #1 RES = 1'b0;
      n = $urandom_range(12, 9);
      for (int i = 0; i < n; i++) step(1'b0);
      for (int c = 0; c < 40; c++) cycle(7, $urandom_range(4, 2));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
